// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Handshaked ALU with registered result and iterative shift-add
//            multiplier (low / high-unsigned product).
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [3:0]      ALUControl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Illegal
);

    localparam int              c_SHW      = $clog2(XLEN);
    localparam logic [c_SHW-1:0] c_CNT_LAST = c_SHW'(XLEN - 1);

    localparam logic [3:0] c_OP_ADD   = 4'b0000;
    localparam logic [3:0] c_OP_SUB   = 4'b0001;
    localparam logic [3:0] c_OP_AND   = 4'b0010;
    localparam logic [3:0] c_OP_OR    = 4'b0011;
    localparam logic [3:0] c_OP_XOR   = 4'b0100;
    localparam logic [3:0] c_OP_SLT   = 4'b0101;
    localparam logic [3:0] c_OP_SLTU  = 4'b0110;
    localparam logic [3:0] c_OP_SLL   = 4'b0111;
    localparam logic [3:0] c_OP_SRL   = 4'b1000;
    localparam logic [3:0] c_OP_SRA   = 4'b1001;
    localparam logic [3:0] c_OP_MUL   = 4'b1010;
    localparam logic [3:0] c_OP_MULHU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               illegal_q, illegal_d;
    logic [2*XLEN-1:0]  mcand_q,  mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [2*XLEN-1:0]  prod_q,   prod_d;
    logic [c_SHW-1:0]   cnt_q,    cnt_d;
    logic               hi_q,     hi_d;

    logic               w_accept;
    logic [c_SHW-1:0]   w_shamt;
    logic [XLEN-1:0]    w_alu_res;
    logic               w_is_mul;
    logic               w_is_illegal;
    logic [2*XLEN-1:0]  w_prod_sum;

    assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (state_q == S_DONE);
    assign ALUResult  = result_q;
    assign Zero       = (result_q == '0);
    assign Illegal    = illegal_q;
    assign w_shamt    = SrcB[c_SHW-1:0];
    assign w_prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        w_alu_res    = '0;
        w_is_mul     = 1'b0;
        w_is_illegal = 1'b0;
        case (ALUControl)
            c_OP_ADD:   w_alu_res = SrcA + SrcB;
            c_OP_SUB:   w_alu_res = SrcA - SrcB;
            c_OP_AND:   w_alu_res = SrcA & SrcB;
            c_OP_OR:    w_alu_res = SrcA | SrcB;
            c_OP_XOR:   w_alu_res = SrcA ^ SrcB;
            c_OP_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            c_OP_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            c_OP_SLL:   w_alu_res = SrcA << w_shamt;
            c_OP_SRL:   w_alu_res = SrcA >> w_shamt;
            c_OP_SRA:   w_alu_res = $signed(SrcA) >>> w_shamt;
            c_OP_MUL,
            c_OP_MULHU: w_is_mul = 1'b1;
            default:    w_is_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;

        case (state_q)
            S_BUSY: begin
                prod_d   = w_prod_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + c_SHW'(1);
                if (cnt_q == c_CNT_LAST) begin
                    result_d = hi_q ? w_prod_sum[2*XLEN-1:XLEN] : w_prod_sum[XLEN-1:0];
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Accept is only possible in IDLE or DONE, so it overrides the above.
        if (w_accept) begin
            illegal_d = 1'b0;
            if (w_is_mul) begin
                mcand_d  = {{XLEN{1'b0}}, SrcA};
                mplier_d = SrcB;
                prod_d   = '0;
                cnt_d    = '0;
                hi_d     = (ALUControl == c_OP_MULHU);
                state_d  = S_BUSY;
            end else if (w_is_illegal) begin
                result_d  = '0;
                illegal_d = 1'b1;
                state_d   = S_DONE;
            end else begin
                result_d = w_alu_res;
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            hi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Directed vectors for alu_multicycle with a queue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam int XLEN      = 32;
    localparam int c_MUL_LAT = XLEN + 1;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [3:0]      ALUControl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    logic            Illegal;

    logic [XLEN-1:0] exp_res;
    logic            exp_ill;
    logic            end_req;
    logic            mon_done;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            ill;
        int              acc;
        int              lat;
    } sb_t;

    sb_t sb_q[$];

    alu_multicycle #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: sole owner of the counters and the scoreboard queue.
    initial begin : monitor
        sb_t             e;
        bit              started;
        bit              post_rst;
        bit              prev_valid;
        bit              prev_xfer;
        logic [XLEN-1:0] prev_res;
        logic            prev_ill;
        int              cyc;
        started = 0; post_rst = 0; prev_valid = 0; prev_xfer = 0;
        prev_res = '0; prev_ill = 1'b0; cyc = 0;
        n_checks = 0; n_fails = 0; mon_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (started) begin
                if (post_rst) begin
                    check("rst_out_valid", XLEN'(out_valid), XLEN'(0));
                    check("rst_result",    ALUResult,        XLEN'(0));
                    check("rst_zero",      XLEN'(Zero),      XLEN'(1));
                    check("rst_illegal",   XLEN'(Illegal),   XLEN'(0));
                    check("rst_in_ready",  XLEN'(in_ready),  XLEN'(1));
                end
                if (out_valid === 1'b1) begin
                    if (!prev_valid || prev_xfer) begin
                        if (sb_q.size() == 0) begin
                            check("spurious_out_valid", XLEN'(out_valid), XLEN'(0));
                        end else begin
                            e = sb_q[0];
                            check("result",  ALUResult,       e.res);
                            check("zero",    XLEN'(Zero),     XLEN'(e.res == '0));
                            check("illegal", XLEN'(Illegal),  XLEN'(e.ill));
                            check("latency", XLEN'(cyc - e.acc), XLEN'(e.lat));
                        end
                    end else begin
                        check("hold_result",  ALUResult,      prev_res);
                        check("hold_illegal", XLEN'(Illegal), XLEN'(prev_ill));
                    end
                    check("in_ready_done", XLEN'(in_ready), XLEN'(out_ready));
                    if (out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
                end else begin
                    if (prev_valid && !prev_xfer)
                        check("out_valid_dropped", XLEN'(out_valid), XLEN'(1));
                    if (sb_q.size() == 0) begin
                        check("in_ready_idle", XLEN'(in_ready), XLEN'(1));
                    end else begin
                        check("not_late", XLEN'((cyc - sb_q[0].acc) < sb_q[0].lat), XLEN'(1));
                        check("in_ready_busy", XLEN'(in_ready), XLEN'(0));
                    end
                end
                if (end_req && !mon_done) begin
                    check("scoreboard_empty", XLEN'(sb_q.size()), XLEN'(0));
                    mon_done = 1'b1;
                end
            end
            if (reset === 1'b1 || flush === 1'b1) begin
                sb_q.delete();
                post_rst = 1;
                started  = 1;
            end else begin
                post_rst = 0;
                if (started && in_valid === 1'b1 && in_ready === 1'b1) begin
                    e.res = exp_res;
                    e.ill = exp_ill;
                    e.acc = cyc;
                    e.lat = (ALUControl == 4'b1010 || ALUControl == 4'b1011) ? c_MUL_LAT : 1;
                    sb_q.push_back(e);
                end
            end
            prev_valid = (out_valid === 1'b1) && !post_rst;
            prev_xfer  = prev_valid && (out_ready === 1'b1);
            prev_res   = ALUResult;
            prev_ill   = Illegal;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] r, input logic ill);
        int waited;
        waited     = 0;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        exp_res    = r;
        exp_ill    = ill;
        in_valid   = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            waited++;
            if (waited > 100) begin
                $display("FAIL issue_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
                $fatal(1, "issue did not complete");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        SrcA     = ~a;
        SrcB     = ~b;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        SrcA = '0; SrcB = '0; ALUControl = 4'b0000;
        exp_res = '0; exp_ill = 1'b0; end_req = 1'b0;
        idle(3);
        reset = 1'b0;

        issue(4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
        issue(4'b0001, 32'd5, 32'd5, 32'd0, 1'b0);
        issue(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        issue(4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        issue(4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        issue(4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
        issue(4'b0111, 32'd1, 32'd33, 32'd2, 1'b0);
        issue(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
        issue(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
        issue(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);

        issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        issue(4'b1010, 32'd3, 32'd5, 32'd15, 1'b0);
        issue(4'b1011, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0);
        idle(40);

        // Backpressure then same-cycle release and accept.
        out_ready = 1'b0;
        issue(4'b0000, 32'd1, 32'd2, 32'd3, 1'b0);
        idle(10);
        out_ready = 1'b1;
        issue(4'b0011, 32'h0000_000A, 32'h0000_0005, 32'h0000_000F, 1'b0);
        idle(3);

        // Flush a multiply in flight; its result must never appear.
        issue(4'b1010, 32'd7, 32'd9, 32'd63, 1'b0);
        idle(10);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(40);

        issue(4'b1111, 32'd3, 32'd4, 32'd0, 1'b1);
        issue(4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
        idle(3);

        // Reset in the middle of a multiply.
        issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        idle(5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        issue(4'b0100, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0);
        idle(5);

        end_req = 1'b1;
        for (int i = 0; i < 20 && !mon_done; i++) @(negedge clk);
        #1;
        if (!mon_done) begin
            $display("FAIL monitor_end: mon_done=%b, expected 1", mon_done);
            $fatal(1, "monitor did not finish");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
